// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two requesters shared access to one single-port RAM.
// Latency: the grant and the RAM command are combinational in the request cycle; write data is
// committed at that edge, and read data returns to the owner in the following (RD) cycle.
// Backpressure: no grant while a read is outstanding; requesters hold req/we/addr/wdata until gnt.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;   // ID of the most recent winner
  logic   rd_owner_q, rd_owner_d;   // ID of the requester waiting for read data

  logic any_req;
  logic winner;
  logic grant;
  logic win_we;

  // Pick the winner: under contention the requester not granted last goes first.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      winner = ~last_gnt_q;
    end else begin
      winner = m1_req & ~m0_req;
    end
    // Reset masks the grant so nothing reaches the RAM while rst_n is low.
    grant  = rst_n & (state_q == IDLE) & any_req;
    win_we = winner ? m1_we : m0_we;
  end

  // State register with synchronous active-low reset; m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Next state: writes stay in IDLE, a granted read spends exactly one cycle in RD.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rd_owner_d = rd_owner_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          last_gnt_d = winner;
          if (!win_we) begin
            state_d    = RD;
            rd_owner_d = winner;
          end
        end
      end
      RD:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RAM command from the winner in a grant cycle, read return to the owner in RD.
  always_comb begin
    m0_gnt    = grant & ~winner;
    m1_gnt    = grant & winner;
    ram_wen   = grant & win_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant) begin
      ram_addr  = winner ? m1_addr  : m0_addr;
      ram_wdata = winner ? m1_wdata : m0_wdata;
    end
    busy      = rst_n & (state_q == RD);
    m0_rvalid = busy & ~rd_owner_q;
    m1_rvalid = busy & rd_owner_q;
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: bench requesters hold their request until granted.
module tb_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Simple synchronous RAM standing in for ram_top (one-cycle read latency).
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= $isunknown(mem[ram_addr[7:0]]) ? '0 : mem[ram_addr[7:0]];
  end

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_req = 1; m0_we = 0; m0_addr = 16'h0040; m0_wdata = 32'h1111_2222;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0041; m1_wdata = 32'h3333_4444;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wen, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wen, busy});
    end
    n_tests++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_ram_bus: addr %0h wdata %0h want 0 0", ram_addr, ram_wdata);
    end
    n_tests++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: m0 %0h m1 %0h want 0 0", m0_rdata, m1_rdata);
    end
    // Release reset with both requesting writes: m0 must win the first contention.
    next_cycle();
    rst_n = 1; m0_we = 1;
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_winner: gnt %b want 10", {m0_gnt, m1_gnt});
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_single_write();
    m0_req = 1; m0_we = 1; m0_addr = 16'h0001; m0_wdata = 32'h0000_0007;
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, ram_wen, busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL write_ctl: gnt0/gnt1/wen/busy %b want 1010", {m0_gnt, m1_gnt, ram_wen, busy});
    end
    n_tests++;
    if (ram_addr !== 16'h0001 || ram_wdata !== 32'h7) begin
      n_fail++;
      $display("FAIL write_bus: addr %0h wdata %0h want 1 7", ram_addr, ram_wdata);
    end
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || m0_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_stays_idle: busy %b rvalid %b want 0 0", busy, m0_rvalid);
    end
  endtask

  task automatic test_readback();
    next_cycle();
    m1_req = 1; m1_we = 0; m1_addr = 16'h0001;
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, ram_wen} !== 3'b010 || ram_addr !== 16'h0001) begin
      n_fail++;
      $display("FAIL readback_gnt: gnt0/gnt1/wen %b addr %0h want 010 1", {m0_gnt, m1_gnt, ram_wen}, ram_addr);
    end
    next_cycle();
    m1_req = 0;
    @(negedge clk);
    n_tests++;
    if ({m1_rvalid, m0_rvalid, busy, m0_gnt, m1_gnt} !== 5'b10100 || m1_rdata !== 32'h7 || m0_rdata !== '0) begin
      n_fail++;
      $display("FAIL readback_data: v1/v0/busy/g0/g1 %b rdata1 %0h rdata0 %0h want 10100 7 0",
               {m1_rvalid, m0_rvalid, busy, m0_gnt, m1_gnt}, m1_rdata, m0_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_one_cycle: rvalid %b rdata %0h busy %b want 0 0 0", m1_rvalid, m1_rdata, busy);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    m0_req = 1; m0_we = 1; m0_addr = 16'h0020; m0_wdata = 32'hAAAA_0000;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0030; m1_wdata = 32'hBBBB_0000;
    for (int i = 0; i < 4; i++) begin
      logic          exp_m1;
      logic [AW-1:0] exp_addr;
      exp_m1   = (i % 2) == 1;
      exp_addr = exp_m1 ? 16'h0030 : 16'h0020;
      @(negedge clk);
      n_tests++;
      if ({m0_gnt, m1_gnt} !== {~exp_m1, exp_m1} || ram_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL contention_%0d: gnt %b addr %0h want %b %0h", i, {m0_gnt, m1_gnt}, ram_addr,
                 {~exp_m1, exp_m1}, exp_addr);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_read_blocking();
    m1_req = 1; m1_we = 1; m1_addr = 16'h0010; m1_wdata = 32'h5A5A_1234;
    next_cycle();
    m1_addr = 16'h0011; m1_wdata = 32'h0000_0099;
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, ram_wen} !== 3'b100) begin
      n_fail++;
      $display("FAIL block_read_gnt: gnt0/gnt1/wen %b want 100", {m0_gnt, m1_gnt, ram_wen});
    end
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    n_tests++;
    if ({busy, m0_gnt, m1_gnt, m0_rvalid} !== 4'b1001 || m0_rdata !== 32'h5A5A_1234) begin
      n_fail++;
      $display("FAIL block_rd_cycle: busy/g0/g1/v0 %b rdata %0h want 1001 5a5a1234", {busy, m0_gnt, m1_gnt, m0_rvalid}, m0_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({m1_gnt, ram_wen, busy} !== 3'b110 || ram_addr !== 16'h0011) begin
      n_fail++;
      $display("FAIL block_m1_next: g1/wen/busy %b addr %0h want 110 11", {m1_gnt, ram_wen, busy}, ram_addr);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
    @(negedge clk);
    n_tests++;
    if (m0_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_gnt: gnt %b want 1", m0_gnt);
    end
    next_cycle();
    m0_req = 0; rst_n = 0;
    @(negedge clk);
    n_tests++;
    if ({m0_rvalid, m1_rvalid, busy, m0_gnt, m1_gnt, ram_wen} !== 6'b0 || m0_rdata !== '0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: v0/v1/busy/g0/g1/wen %b rdata %0h addr %0h want 0",
               {m0_rvalid, m1_rvalid, busy, m0_gnt, m1_gnt, ram_wen}, m0_rdata, ram_addr);
    end
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (m0_rvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_late_rvalid: rvalid %b busy %b want 0 0", m0_rvalid, busy);
    end
    next_cycle();
    m1_req = 1; m1_we = 1; m1_addr = 16'h0012; m1_wdata = 32'h0000_0042;
    @(negedge clk);
    n_tests++;
    if ({m1_gnt, ram_wen} !== 2'b11 || ram_addr !== 16'h0012) begin
      n_fail++;
      $display("FAIL midrst_recover: g1/wen %b addr %0h want 11 12", {m1_gnt, ram_wen}, ram_addr);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_hold_and_drop();
    // A request raised during RD waits, then is arbitrated in the next IDLE cycle.
    m0_req = 1; m0_we = 0; m0_addr = 16'h0001;
    next_cycle();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0050; m1_wdata = 32'h0000_0050;
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL hold_no_gnt_in_rd: g0/g1/busy %b want 001", {m0_gnt, m1_gnt, busy});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({m1_gnt, ram_wen} !== 2'b11 || ram_addr !== 16'h0050) begin
      n_fail++;
      $display("FAIL hold_gnt_after_rd: g1/wen %b addr %0h want 11 50", {m1_gnt, ram_wen}, ram_addr);
    end
    next_cycle();
    clear_inputs();
    // A request withdrawn during RD must leave no trace on the RAM bus.
    m0_req = 1; m0_we = 0; m0_addr = 16'h0001;
    next_cycle();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0051; m1_wdata = 32'h0000_0051;
    next_cycle();
    m1_req = 0;
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, ram_wen} !== 3'b000 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL drop_no_access: g0/g1/wen %b addr %0h want 000 0", {m0_gnt, m1_gnt, ram_wen}, ram_addr);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_stream();
    logic [DW-1:0] expv;
    for (int k = 1; k <= 8; k++) begin
      expv = 32'(6 + k);
      m0_req = 1; m0_we = 0; m0_addr = AW'(k);
      next_cycle();
      m0_req = 0;
      @(negedge clk);
      n_tests++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== expv) begin
        n_fail++;
        $display("FAIL stream_read_%0d: rvalid %b rdata %0h want 1 %0h", k, m0_rvalid, m0_rdata, expv);
      end
      next_cycle();
      m0_req = 1; m0_we = 1; m0_addr = AW'(k + 1); m0_wdata = expv + 1;
      next_cycle();
      m0_req = 0;
    end
    m0_req = 1; m0_we = 0; m0_addr = 16'h0009;
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    n_tests++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL stream_final: rvalid %b rdata %0h want 1 f", m0_rvalid, m0_rdata);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [0:15];
    int            m_last, m_owner, w;
    bit            m_rd;
    logic [DW-1:0] m_rexp;
    logic          e_g0, e_g1, e_v0, e_v1, e_busy, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd0, e_rd1;
    logic          g0s, g1s;
    int            run0, run1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    apply_reset();
    m_last = 1; m_rd = 0; m_owner = 0; m_rexp = '0;
    run0 = 0; run1 = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 10) rst_n = ($urandom_range(0, 59) != 0);
      e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_busy = 0; e_wen = 0;
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0; w = 0;
      if (rst_n) begin
        if (m_rd) begin
          e_busy = 1;
          if (m_owner == 0) begin e_v0 = 1; e_rd0 = m_rexp; end
          else begin e_v1 = 1; e_rd1 = m_rexp; end
        end else if (m0_req || m1_req) begin
          if (m0_req && m1_req) w = 1 - m_last;
          else w = m1_req ? 1 : 0;
          e_g0 = (w == 0); e_g1 = (w == 1);
          e_wen   = (w == 0) ? m0_we    : m1_we;
          e_addr  = (w == 0) ? m0_addr  : m1_addr;
          e_wdata = (w == 0) ? m0_wdata : m1_wdata;
        end
      end
      @(negedge clk);
      n_tests++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, ram_wen} !== {e_g0, e_g1, e_v0, e_v1, e_busy, e_wen}) begin
        n_fail++;
        $display("FAIL rand_ctl cyc %0d: g0/g1/v0/v1/busy/wen %b want %b", cyc,
                 {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, ram_wen}, {e_g0, e_g1, e_v0, e_v1, e_busy, e_wen});
      end
      n_tests++;
      if (ram_addr !== e_addr || ram_wdata !== e_wdata) begin
        n_fail++;
        $display("FAIL rand_bus cyc %0d: addr %0h wdata %0h want %0h %0h", cyc, ram_addr, ram_wdata, e_addr, e_wdata);
      end
      n_tests++;
      if (m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
        n_fail++;
        $display("FAIL rand_rdata cyc %0d: rd0 %0h rd1 %0h want %0h %0h", cyc, m0_rdata, m1_rdata, e_rd0, e_rd1);
      end
      // Under continuous contention no requester may win twice in a row.
      if (m0_req && m1_req && (m0_gnt || m1_gnt)) begin
        run0 = m0_gnt ? run0 + 1 : 0;
        run1 = m1_gnt ? run1 + 1 : 0;
        n_tests++;
        if (run0 > 1 || run1 > 1) begin
          n_fail++;
          $display("FAIL rand_starvation cyc %0d: consecutive wins m0 %0d m1 %0d want <= 1", cyc, run0, run1);
        end
      end else if (m0_gnt || m1_gnt) begin
        run0 = 0; run1 = 0;
      end
      g0s = m0_gnt; g1s = m1_gnt;
      next_cycle();
      if (!rst_n) begin
        m_rd = 0; m_last = 1; run0 = 0; run1 = 0;
      end else if (m_rd) begin
        m_rd = 0;
      end else if (e_g0 || e_g1) begin
        m_last = w;
        if (e_wen) ref_mem[e_addr[3:0]] = e_wdata;
        else begin m_rd = 1; m_owner = w; m_rexp = ref_mem[e_addr[3:0]]; end
      end
      if (!m0_req || g0s) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_we = $urandom_range(0, 1) == 1;
        m0_addr = 16'h0080 + AW'($urandom_range(0, 15)); m0_wdata = $urandom;
      end
      if (!m1_req || g1s) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_we = $urandom_range(0, 1) == 1;
        m1_addr = 16'h0080 + AW'($urandom_range(0, 15)); m1_wdata = $urandom;
      end
    end
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_read_blocking();
    test_reset_mid_read();
    test_hold_and_drop();
    test_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports m0_req / m1_req  input  1  requester 0/1 access request.
REQ-006 The block SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports m0_addr / m1_addr  input  ADDR_W  access address.
REQ-008 The block SHALL have ports m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-009 The block SHALL have ports m0_gnt / m1_gnt  output  1  request accepted this cycle.
REQ-010 The block SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid this cycle.
REQ-011 The block SHALL have ports m0_rdata / m1_rdata  output  DATA_W  read data.
REQ-012 The block SHALL have port ram_addr  output  ADDR_W  address to ram_top.
REQ-013 The block SHALL have port ram_wdata  output  DATA_W  write data to ram_top.
REQ-014 The block SHALL have port ram_wen  output  1  write enable to ram_top.
REQ-015 The block SHALL have port ram_rdata  input  DATA_W  read data from ram_top; valid one cycle after the address is presented with ram_wen=0.
REQ-016 The block SHALL have port busy  output  1  high while in state RD.

Function
REQ-017 The FSM SHALL have two states: IDLE (may grant) and RD (waiting for read data; no grant).
REQ-018 In IDLE with at least one req high, exactly one gnt SHALL assert combinationally in that cycle; no gnt SHALL assert in RD.
REQ-019 Under contention, the requester not granted most recently SHALL win (round-robin); a register last_gnt SHALL record the winner on every grant.
REQ-020 With a single requester active, that requester SHALL be granted in IDLE regardless of last_gnt.
REQ-021 In a grant cycle, ram_addr, ram_wdata and ram_wen SHALL be driven combinationally from the winner's addr, wdata and we; otherwise they SHALL be 0.
REQ-022 A granted write SHALL complete at the same clock edge, the FSM SHALL stay in IDLE, and back-to-back writes SHALL sustain 1 per cycle.
REQ-023 A granted read SHALL move the FSM to RD and latch the winner's ID into rd_owner.
REQ-024 In RD, the owner's rvalid SHALL be high for exactly one cycle with rdata = ram_rdata, and the FSM SHALL return to IDLE at the next edge, so reads sustain 1 per 2 cycles.
REQ-025 m*_rdata SHALL be 0 whenever the corresponding rvalid is low.
REQ-026 Requesters SHALL hold req, we, addr and wdata stable until gnt; a deasserted req before gnt SHALL be dropped with no RAM access.
REQ-027 A requester that keeps req high during RD SHALL be arbitrated normally in the following IDLE cycle.
REQ-028 Starvation bound: under continuous contention, each requester SHALL be granted at least once every 2 grants.

Reset
REQ-029 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, last_gnt SHALL be set to 1 (m0 wins the first contention), and rd_owner SHALL be set to 0.
REQ-030 While rst_n is low, all gnt, rvalid, rdata, ram_wen, ram_addr, ram_wdata and busy outputs SHALL be 0.
REQ-031 A reset asserted during RD SHALL abandon the read, and no rvalid SHALL follow it.

Verification
REQ-032 Single write: m0 writes addr 0x0001, data 0x00000007 -> m0_gnt=1 and ram_wen=1 in the same cycle, FSM stays IDLE.
REQ-033 Read-back: m1 reads 0x0001 after scenario 1 -> m1_gnt in cycle N; m1_rvalid=1 and m1_rdata=0x00000007 in cycle N+1; m0_rvalid stays 0.
REQ-034 Contention: m0 and m1 both hold write req for 4 cycles after reset -> grant order m0, m1, m0, m1; ram_addr alternates between the two addresses.
REQ-035 Read blocking: m0 reads 0x0010 while m1 holds a write req -> m0 granted, busy=1 for one cycle with no gnt, m1 granted in the next cycle.
REQ-036 Reset mid-read: m0 read is granted, then rst_n=0 in the RD cycle -> no m0_rvalid; all outputs 0; next request is granted normally from IDLE.
REQ-037 Streaming increment: sequence of reads of addr k, then writes of rdata+1 to addr k+1, for k=1..8, starting from 7 at addr 1 -> final RAM[9]=0x0000000F.
